div_unit: RTL and testbench



---
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider with HI/LO result registers
// Signed operands are reduced to magnitudes; result signs are fixed up in FIX.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sinal,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [1:0]       Estado
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  dabs_q, dabs_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              dz_q, dz_d;

  // The shifted partial remainder needs WIDTH+1 bits when |divisor| > 2^(WIDTH-1).
  logic [WIDTH:0]    r_ext;
  logic [WIDTH:0]    diff;

  assign r_ext = {r_q, q_q[WIDTH-1]};
  assign diff  = r_ext - {1'b0, dabs_q};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dabs_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dabs_q  <= dabs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dabs_d  = dabs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Divisor == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = (Sinal && Dividendo[WIDTH-1]) ? -Dividendo : Dividendo;
            dabs_d  = (Sinal && Divisor[WIDTH-1])   ? -Divisor   : Divisor;
            neg_q_d = Sinal & (Dividendo[WIDTH-1] ^ Divisor[WIDTH-1]);
            neg_r_d = Sinal & Dividendo[WIDTH-1];
            r_d     = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_ext[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = neg_q_q ? -q_q : q_q;
        hi_d    = neg_r_q ? -r_q : r_q;
        state_d = DONE;
      end
      DONE: begin
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = (state_q == CALC) || (state_q == FIX);
  assign Done    = (state_q == DONE);
  assign DivZero = (state_q == DONE) && dz_q;
  assign Estado  = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
// Stimulus pushes expected results; a negedge monitor pops them on each Done.
module tb_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Sinal = 1'b0;
  logic [31:0] Dividendo = '0;
  logic [31:0] Divisor = '0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivZero;
  logic [1:0]  Estado;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sinal(Sinal),
    .Dividendo(Dividendo), .Divisor(Divisor), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Estado(Estado)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
    int          busy;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_pushed = 0;
  int   n_done = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: one scoreboard entry per Done pulse.
  always @(negedge Clock) begin
    if (Busy) busy_cnt++;
    if (Done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_lo"}, Lo, e.lo);
        chk({e.name, "_hi"}, Hi, e.hi);
        chk({e.name, "_dz"}, 32'(DivZero), 32'(e.dz));
        chk({e.name, "_lat"}, 32'(cyc - e.start_cyc), 32'(e.lat));
        chk({e.name, "_busy"}, 32'(busy_cnt), 32'(e.busy));
        chk({e.name, "_busy_done_excl"}, 32'(Busy), 32'd0);
      end
      busy_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Estado != 2'd0 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (Estado != 2'd0) chk("wait_idle_timeout", 32'(Estado), 32'd0);
  endtask

  task automatic issue(input string name, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic push,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    exp_t e;
    wait_idle();
    @(negedge Clock);
    Start = 1'b1; Sinal = s; Dividendo = a; Divisor = b;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Dividendo = 32'hDEAD_BEEF;
    Divisor   = 32'h0000_0003;
    Sinal     = ~s;
    if (push) begin
      e.name = name; e.lo = elo; e.hi = ehi; e.dz = edz;
      e.lat = edz ? 0 : 33;
      e.busy = edz ? 0 : 33;
      e.start_cyc = cyc;
      sb.push_back(e);
      n_pushed++;
    end
  endtask

  initial begin
    int n;
    #12;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_flags", {29'd0, Busy, Done, DivZero}, 32'd0);
    chk("rst_state", 32'(Estado), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    issue("udiv16", 1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
    issue("sneg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue("s7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
    issue("sneg8_neg3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, 1'b0);
    issue("u_bigdiv", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b0);
    issue("u100_7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    issue("divzero", 1'b1, 32'd123, 32'd0, 1'b1, 32'd14, 32'd2, 1'b1);
    issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);

    // A second Start while busy must be ignored.
    issue("restart50_5", 1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);
    repeat (9) @(negedge Clock);
    Start = 1'b1; Dividendo = 32'd9; Divisor = 32'd3;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();
    repeat (3) @(negedge Clock);
    chk("restart_state_idle", 32'(Estado), 32'd0);
    chk("restart_one_done", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of CALC discards the operation.
    issue("aborted", 1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (15) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    chk("midrst_state", 32'(Estado), 32'd0);
    @(negedge Clock);
    busy_cnt = 0;
    Reset = 1'b1;
    issue("after_rst_1_1", 1'b0, 32'd1, 32'd1, 1'b1, 32'd1, 32'd0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (5) @(negedge Clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
